// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences a shared-ALU / shared-memory datapath.
// Optional performance counters are enabled by defining CTRL_PERF_EN.
module multicycle_ctrl #(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       ir_write_o,
  output logic       reg_write_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       iord_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic       pc_src_o,
  output logic [1:0] wb_sel_o,
  output logic       illegal_o,
  output logic [3:0] state_o
`ifdef CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt_o,
  output logic [31:0] instret_o
`endif
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_ALU_WB   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_LOAD_WB  = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_ILLEGAL  = 4'd12
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;

  always_comb begin
    state_d     = state_q;
    pc_write_o  = 1'b0;
    ir_write_o  = 1'b0;
    reg_write_o = 1'b0;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    iord_o      = 1'b0;
    alu_src_a_o = 2'b00;
    alu_src_b_o = 2'b00;
    alu_op_o    = 2'b00;
    pc_src_o    = 1'b0;
    wb_sel_o    = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'b10;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
        if (mem_ready_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        case (opcode_i)
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a_o = 2'b01;
        alu_op_o    = 2'b10;
        state_d     = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
        alu_op_o    = 2'b10;
        state_d     = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_o = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
        state_d     = (opcode_i == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
        if (mem_ready_i) state_d = S_LOAD_WB;
      end
      S_LOAD_WB: begin
        reg_write_o = 1'b1;
        wb_sel_o    = 2'b01;
        state_d     = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
        if (mem_ready_i) state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_o = 2'b01;
        alu_op_o    = 2'b01;
        pc_src_o    = 1'b1;
        pc_write_o  = zero_i;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        reg_write_o = 1'b1;
        wb_sel_o    = 2'b10;
        pc_src_o    = 1'b1;
        pc_write_o  = 1'b1;
        state_d     = S_FETCH;
      end
      S_JALR: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
        pc_write_o  = 1'b1;
        reg_write_o = 1'b1;
        wb_sel_o    = 2'b10;
        state_d     = S_FETCH;
      end
      S_ILLEGAL: state_d = ILLEGAL_HALT ? S_ILLEGAL : S_FETCH;
      default:   state_d = S_FETCH;
    endcase
    // Reset overrides the decode so nothing is requested or written on a reset cycle.
    if (!rst_i) begin
      pc_write_o  = 1'b0;
      ir_write_o  = 1'b0;
      reg_write_o = 1'b0;
      mem_read_o  = 1'b0;
      mem_write_o = 1'b0;
      iord_o      = 1'b0;
      alu_src_a_o = 2'b00;
      alu_src_b_o = 2'b00;
      alu_op_o    = 2'b00;
      pc_src_o    = 1'b0;
      wb_sel_o    = 2'b00;
    end
  end

  assign illegal_d = illegal_q | (state_d == S_ILLEGAL);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  assign illegal_o = illegal_q;
  assign state_o   = state_q;

`ifdef CTRL_PERF_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instret_q, instret_d;
  logic        retire;

  always_comb begin
    retire = 1'b0;
    if (state_d == S_FETCH) begin
      case (state_q)
        S_ALU_WB, S_LOAD_WB, S_MEM_WR, S_BRANCH, S_JAL, S_JALR: retire = 1'b1;
        default: retire = 1'b0;
      endcase
    end
    cycle_cnt_d = cycle_cnt_q + 32'd1;
    instret_d   = instret_q + {31'd0, retire};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cycle_cnt_q <= '0;
      instret_q   <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instret_q   <= instret_d;
    end
  end

  assign cycle_cnt_o = cycle_cnt_q;
  assign instret_o   = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard bench for multicycle_ctrl (ILLEGAL_HALT=1).
// Counter checks are compiled in when CTRL_PERF_EN is defined.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       irw;
    logic       rw;
    logic       mr;
    logic       mw;
    logic       iord;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] op;
    logic       pcs;
    logic [1:0] wb;
    logic       ill;
  } vec_t;

  localparam logic [6:0] R   = 7'b0110011;
  localparam logic [6:0] I   = 7'b0010011;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] JR  = 7'b1100111;
  localparam logic [6:0] BAD = 7'b1111111;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [6:0] opcode_i;
  logic       zero_i;
  logic       mem_ready_i;
  logic       pc_write_o, ir_write_o, reg_write_o, mem_read_o, mem_write_o, iord_o;
  logic [1:0] alu_src_a_o, alu_src_b_o, alu_op_o, wb_sel_o;
  logic       pc_src_o, illegal_o;
  logic [3:0] state_o;
`ifdef CTRL_PERF_EN
  logic [31:0] cycle_cnt_o, instret_o;
`endif

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic        exp_ill = 1'b0;
  vec_t        sb_q[$];

  always #5 clk_i = ~clk_i;

  multicycle_ctrl #(.ILLEGAL_HALT(1'b1)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .opcode_i    (opcode_i),
    .zero_i      (zero_i),
    .mem_ready_i (mem_ready_i),
    .pc_write_o  (pc_write_o),
    .ir_write_o  (ir_write_o),
    .reg_write_o (reg_write_o),
    .mem_read_o  (mem_read_o),
    .mem_write_o (mem_write_o),
    .iord_o      (iord_o),
    .alu_src_a_o (alu_src_a_o),
    .alu_src_b_o (alu_src_b_o),
    .alu_op_o    (alu_op_o),
    .pc_src_o    (pc_src_o),
    .wb_sel_o    (wb_sel_o),
    .illegal_o   (illegal_o),
    .state_o     (state_o)
`ifdef CTRL_PERF_EN
    ,
    .cycle_cnt_o (cycle_cnt_o),
    .instret_o   (instret_o)
`endif
  );

  // Expected outputs for a given state, straight from the per-state output table.
  function automatic vec_t model(input logic [3:0] st, input logic z, input logic rdy,
                                 input logic rstn, input logic ill);
    vec_t v;
    v     = '0;
    v.st  = st;
    v.ill = ill;
    if (rstn) begin
      case (st)
        4'd0:  begin v.mr = 1'b1; v.sb = 2'b10; v.irw = rdy; v.pcw = rdy; end
        4'd1:  begin v.sa = 2'b10; v.sb = 2'b01; end
        4'd2:  begin v.sa = 2'b01; v.op = 2'b10; end
        4'd3:  begin v.sa = 2'b01; v.sb = 2'b01; v.op = 2'b10; end
        4'd4:  v.rw = 1'b1;
        4'd5:  begin v.sa = 2'b01; v.sb = 2'b01; end
        4'd6:  begin v.mr = 1'b1; v.iord = 1'b1; end
        4'd7:  begin v.rw = 1'b1; v.wb = 2'b01; end
        4'd8:  begin v.mw = 1'b1; v.iord = 1'b1; end
        4'd9:  begin v.sa = 2'b01; v.op = 2'b01; v.pcs = 1'b1; v.pcw = z; end
        4'd10: begin v.rw = 1'b1; v.wb = 2'b10; v.pcs = 1'b1; v.pcw = 1'b1; end
        4'd11: begin v.sa = 2'b01; v.sb = 2'b01; v.pcw = 1'b1; v.rw = 1'b1; v.wb = 2'b10; end
        default: ;
      endcase
    end
    return v;
  endfunction

  task automatic check_front();
    vec_t e, a;
    e = sb_q.pop_front();
    a = {state_o, pc_write_o, ir_write_o, reg_write_o, mem_read_o, mem_write_o, iord_o,
         alu_src_a_o, alu_src_b_o, alu_op_o, pc_src_o, wb_sel_o, illegal_o};
    vectors++;
    assert (a === e) else begin
      miscompares++;
      $error("FAIL vec%0d st%0d observed=%h expected=%h", vectors, e.st, a, e);
    end
  endtask

  // One clock: drive inputs at the falling edge, then compare the settled outputs.
  task automatic step(input logic [6:0] op, input logic z, input logic rdy,
                      input logic rstn, input logic [3:0] st);
    @(negedge clk_i);
    opcode_i    = op;
    zero_i      = z;
    mem_ready_i = rdy;
    rst_i       = rstn;
    #1;
    sb_q.push_back(model(st, z, rdy, rstn, exp_ill));
    check_front();
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b0; opcode_i = '0; zero_i = 1'b0; mem_ready_i = 1'b1;
    step(R, 0, 1, 0, 4'd0);
    // R-type; mem_ready low outside memory states must not stall
    step(R, 0, 1, 1, 4'd0); step(R, 0, 0, 1, 4'd1); step(R, 0, 0, 1, 4'd2); step(R, 1, 0, 1, 4'd4);
    // I-type with one fetch wait cycle
    step(I, 0, 0, 1, 4'd0); step(I, 0, 1, 1, 4'd0); step(I, 0, 1, 1, 4'd1);
    step(I, 0, 1, 1, 4'd3); step(I, 0, 1, 1, 4'd4);
    // load with two wait cycles in MEM_RD
    step(LD, 0, 1, 1, 4'd0); step(LD, 0, 1, 1, 4'd1); step(LD, 0, 1, 1, 4'd5);
    step(LD, 0, 0, 1, 4'd6); step(LD, 0, 0, 1, 4'd6); step(LD, 0, 1, 1, 4'd6);
    step(LD, 0, 1, 1, 4'd7);
    // store with one wait cycle
    step(ST, 0, 1, 1, 4'd0); step(ST, 0, 1, 1, 4'd1); step(ST, 0, 1, 1, 4'd5);
    step(ST, 0, 0, 1, 4'd8); step(ST, 0, 1, 1, 4'd8);
    // branch taken / not taken
    step(BR, 0, 1, 1, 4'd0); step(BR, 0, 1, 1, 4'd1); step(BR, 1, 1, 1, 4'd9);
    step(BR, 0, 1, 1, 4'd0); step(BR, 0, 1, 1, 4'd1); step(BR, 0, 1, 1, 4'd9);
    // JAL then JALR
    step(JL, 0, 1, 1, 4'd0); step(JL, 0, 1, 1, 4'd1); step(JL, 0, 1, 1, 4'd10);
    step(JR, 0, 1, 1, 4'd0); step(JR, 0, 1, 1, 4'd1); step(JR, 0, 1, 1, 4'd11);
    // reset during a store wait: request dropped, then FETCH
    step(ST, 0, 1, 1, 4'd0); step(ST, 0, 1, 1, 4'd1); step(ST, 0, 1, 1, 4'd5);
    step(ST, 0, 0, 1, 4'd8); step(ST, 0, 0, 0, 4'd8); step(R, 0, 0, 1, 4'd0);
    // illegal opcode halts with sticky flag
    step(BAD, 0, 1, 1, 4'd0); step(BAD, 0, 1, 1, 4'd1);
    exp_ill = 1'b1;
    for (int i = 0; i < 20; i++) step(BAD, 1'($urandom), 1'($urandom), 1, 4'd12);
    step(BAD, 0, 1, 0, 4'd12);
    exp_ill = 1'b0;
    step(R, 0, 1, 1, 4'd0); step(R, 0, 1, 1, 4'd1); step(R, 0, 1, 1, 4'd2); step(R, 0, 1, 1, 4'd4);
`ifdef CTRL_PERF_EN
    step(R, 0, 1, 0, 4'd0);
    for (int k = 0; k < 3; k++) begin
      step(R, 0, 1, 1, 4'd0); step(R, 0, 1, 1, 4'd1); step(R, 0, 1, 1, 4'd2); step(R, 0, 1, 1, 4'd4);
    end
    @(negedge clk_i); #1;
    check32("cycle_cnt", cycle_cnt_o, 32'd12);
    check32("instret", instret_o, 32'd3);
    step(R, 0, 1, 1, 4'd1); step(R, 0, 1, 1, 4'd2); step(R, 0, 1, 1, 4'd4);
    dut.cycle_cnt_q = '1;
    dut.instret_q   = '1;
    @(negedge clk_i); #1;
    check32("cycle_wrap", cycle_cnt_o, 32'd0);
    check32("instret_wrap", instret_o, 32'd0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore/Mealy control FSM that sequences a shared-ALU, shared-memory RV32I datapath over multiple cycles.
- Sits beside the datapath and replaces the single-cycle decoder: drives register/PC/IR enables, mux selects and ALUOp.
- Handshakes with a variable-latency unified memory through mem_ready_i.

Parameters:
ILLEGAL_HALT, 1, 1 = illegal opcode halts the FSM until reset; 0 = illegal opcode treated as NOP, return to FETCH.

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous active-low reset
opcode_i  in  7  instr[6:0] from the instruction register
zero_i  in  1  ALU Zero flag
mem_ready_i  in  1  memory completes current access this cycle
pc_write_o  out  1  PC register enable
ir_write_o  out  1  instruction register enable
reg_write_o  out  1  register file write enable
mem_read_o  out  1  memory read request
mem_write_o  out  1  memory write request
iord_o  out  1  memory address select: 0 = PC, 1 = ALUOut
alu_src_a_o  out  2  00 = PC, 01 = rs1, 10 = oldPC
alu_src_b_o  out  2  00 = rs2, 01 = imm, 10 = constant 4
alu_op_o  out  2  00 = add, 01 = branch compare, 10 = funct-decoded
pc_src_o  out  1  0 = ALU result, 1 = ALUOut register
wb_sel_o  out  2  00 = ALUOut, 01 = MDR, 10 = PC (already PC+4)
illegal_o  out  1  sticky illegal-opcode flag
state_o  out  4  current state encoding, for debug

Behaviour:
- Reset: rst_i is sampled low at a clock edge -> state = FETCH and illegal_o = 0.
- While rst_i is low, all enables and requests (pc_write, ir_write, reg_write, mem_read, mem_write) are forced to 0. All selects are forced to 0.
- Outputs are decoded combinationally from the state register. The only Mealy terms are the mem_ready_i gating and the zero_i gating in BRANCH.
- States and encodings, with the outputs asserted in each (unlisted outputs are 0):
  - FETCH (0): mem_read=1, iord=0, srcA=00, srcB=10, aluop=00, pc_src=0. ir_write and pc_write = mem_ready_i. Stays in FETCH until mem_ready_i=1, then goes to DECODE.
  - DECODE (1): srcA=10, srcB=01, aluop=00 (branch/JAL target latched into ALUOut). Next state by opcode:
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 0000011 or 0100011 -> MEM_ADDR
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR
    - any other value -> ILLEGAL
  - EXEC_R (2): srcA=01, srcB=00, aluop=10 -> ALU_WB.
  - EXEC_I (3): srcA=01, srcB=01, aluop=10 -> ALU_WB.
  - ALU_WB (4): reg_write=1, wb_sel=00 -> FETCH.
  - MEM_ADDR (5): srcA=01, srcB=01, aluop=00 -> MEM_RD if opcode_i=0000011, else MEM_WR.
  - MEM_RD (6): mem_read=1, iord=1. Holds until mem_ready_i=1, then LOAD_WB.
  - LOAD_WB (7): reg_write=1, wb_sel=01 -> FETCH.
  - MEM_WR (8): mem_write=1, iord=1. Holds until mem_ready_i=1, then FETCH.
  - BRANCH (9): srcA=01, srcB=00, aluop=01, pc_src=1, pc_write=zero_i -> FETCH.
  - JAL (10): reg_write=1, wb_sel=10, pc_src=1, pc_write=1 -> FETCH.
  - JALR (11): srcA=01, srcB=01, aluop=00, pc_src=0, pc_write=1, reg_write=1, wb_sel=10 -> FETCH. rd==rs1 is safe because the RF write lands at the edge.
  - ILLEGAL (12): illegal_o=1, all enables 0.
    - ILLEGAL_HALT=1: stays in ILLEGAL until reset.
    - ILLEGAL_HALT=0: goes to FETCH after one cycle; illegal_o stays sticky until reset.
- Memory handshake:
  - mem_read/mem_write and iord are held stable every cycle until mem_ready_i is sampled high.
  - A request drops in the cycle after completion.
  - mem_ready_i is ignored in every state that is not a memory state.
- CPI with mem_ready_i tied to 1: R/I = 4, load = 5, store = 4, branch/JAL/JALR = 3.
- Each extra wait cycle on a memory access adds 1 cycle.
- Unused state encodings 13–15 go to FETCH on the next edge, with all outputs 0 while in them.
- Reset mid-instruction (including mid-wait): the pending request is abandoned. No write enable asserts on the reset cycle.

Optional Feature:
CTRL_PERF_EN
- Defined: adds ports cycle_cnt_o[31:0] and instret_o[31:0], both reset to 0.
  - cycle_cnt_o increments every non-reset cycle.
  - instret_o increments on each transition into FETCH from ALU_WB, LOAD_WB, MEM_WR, BRANCH, JAL or JALR.
  - Both counters wrap modulo 2^32. ILLEGAL never counts as retired.
- Undefined: these ports and counters are absent. All other behaviour is identical.

Test Plan:
- R-type add, opcode 0110011, mem_ready_i=1 -> state sequence 0,1,2,4,0. reg_write high only in state 4. 4 cycles total.
- Load, opcode 0000011, mem_ready_i low for 2 cycles in MEM_RD -> sequence 0,1,5,6,6,6,7,0. mem_read and iord=1 steady throughout MEM_RD. 7 cycles.
- Branch in state 9: zero_i=1 -> pc_write=1, pc_src=1. zero_i=0 -> pc_write=0. Both cases return to FETCH after 3 cycles.
- JAL 1101111 then JALR 1100111 -> in states 10 and 11: reg_write=1, wb_sel=10, pc_write=1. pc_src is 1 in JAL, 0 in JALR.
- Opcode 1111111 with ILLEGAL_HALT=1 -> state 12 and illegal_o=1 held for 20 cycles. rst_i=0 for 1 edge -> state 0, illegal_o=0.
- CTRL_PERF_EN: 3 R-type instructions from reset -> instret_o=3, cycle_cnt_o=12. Counters preset to 32'hFFFFFFFF -> both wrap to 0.
